act_stream_ctrl: RTL

ACT_STREAM_CTRL -- requirements
Module: act_stream_ctrl

---
 rtl/dpu_act_pkg.sv | 16 +
 rtl/act_out_fifo.sv | 68 ++++++
 rtl/act_stream_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dpu_act_pkg.sv
// dpu_act_pkg -- shared definitions for the activation streaming controller.
//   LRELU_SHIFT        : right-shift applied to negative words (leaky-ReLU slope 1/8)
//   DEFAULT_FIFO_DEPTH : default output FIFO depth
//   state_t            : controller sequencing states
package dpu_act_pkg;

  localparam int unsigned LRELU_SHIFT        = 3;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/act_out_fifo.sv
// act_out_fifo -- synchronous FIFO holding activated words plus their last flag.
//   clk, rst    : clock, synchronous active-high reset (empties the FIFO)
//   push        : write push_data (ignored when full unless a pop happens too)
//   push_data   : WIDTH-bit entry
//   pop         : remove head entry (ignored when empty)
//   pop_data    : head entry (meaningful when !empty)
//   empty       : no entries stored
//   count       : current occupancy, 0..DEPTH
module act_out_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem[rd_ptr];
  assign count    = cnt;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/act_stream_ctrl.sv
// act_stream_ctrl -- streams a job of INT32 words from the accumulator buffer,
// applies leaky-ReLU (negative x -> x >>> 3) and delivers them on a
// valid/ready output through a small FIFO.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a job (accepted when idle, or in the done cycle)
//   base_addr, count  : job first address and word count, latched at start
//   cfg_bypass        : (ACT_STREAM_CTRL_BYPASS_EN only) pass words unchanged
//   busy, done        : job in progress / one-cycle completion pulse
//   mem_rd_en/addr    : buffer read request; mem_rd_data returns one cycle later
//   out_valid/ready   : output handshake; out_data, out_last accompany it
// Optional feature macro: ACT_STREAM_CTRL_BYPASS_EN
module act_stream_ctrl
  import dpu_act_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
`ifdef ACT_STREAM_CTRL_BYPASS_EN
  input  logic              cfg_bypass,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_last
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remain_q;
  logic              rd_pend;
  logic              rd_pend_last;
  logic              bypass_q;

  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_empty;
  logic [32:0]       fifo_head;
  logic [CNT_W:0]    occ;
  logic              issue;
  logic              last_issue;
  logic              done_c;
  logic              accept;
  logic              bypass_in;
  logic [31:0]       act_y;

`ifdef ACT_STREAM_CTRL_BYPASS_EN
  assign bypass_in = cfg_bypass;
`else
  assign bypass_in = 1'b0;
`endif

  // Reads in flight are reserved FIFO space so the FIFO can never overflow.
  assign occ        = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, rd_pend};
  assign issue      = (state == RUN) && (occ < (CNT_W+1)'(FIFO_DEPTH));
  assign last_issue = issue && (remain_q == (ADDR_W+1)'(1));

  // In DRAIN, an empty FIFO with nothing in flight means the final handshake
  // has already happened, so this cycle is the done cycle.
  assign done_c = (state == DRAIN) && !rd_pend && fifo_empty;
  // The done cycle behaves as idle so a back-to-back start is not lost.
  assign accept = start && ((state == IDLE) || done_c);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DRAIN: begin
        if (done_c) begin
          state_nx = IDLE;
        end
        if (accept) begin
          state_nx = (count == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (last_issue) begin
          state_nx = DRAIN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      bypass_q     <= 1'b0;
    end else begin
      state        <= state_nx;
      rd_pend      <= issue;
      rd_pend_last <= last_issue;
      if (accept) begin
        addr_q   <= base_addr;
        remain_q <= count;
        bypass_q <= bypass_in;
      end else if (issue) begin
        addr_q   <= addr_q + ADDR_W'(1);
        remain_q <= remain_q - (ADDR_W+1)'(1);
      end
    end
  end

  always_comb begin
    act_y = mem_rd_data;
    if (mem_rd_data[31] && !bypass_q) begin
      act_y = $signed(mem_rd_data) >>> LRELU_SHIFT;
    end
  end

  act_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend),
    .push_data ({rd_pend_last, act_y}),
    .pop       (out_ready),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign busy        = (state != IDLE) && !done_c;
  assign done        = done_c;
  assign mem_rd_en   = issue;
  assign mem_rd_addr = addr_q;
  assign out_valid   = !fifo_empty;
  assign out_data    = fifo_empty ? '0 : fifo_head[31:0];
  assign out_last    = !fifo_empty && fifo_head[32];

endmodule
